// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the reduced RISC-V core: sequences FETCH/DECODE/EXEC/MEM/WB
// over a single shared memory port, traps illegal opcodes and counts retired instructions.
module multicycle_control #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] instr,
    input  logic                     EQ,
    input  logic                     mem_ready,
    output logic                     InstrRead,
    output logic                     IRWrite,
    output logic                     MemRead,
    output logic                     MemWrite,
    output logic                     RegWrite,
    output logic [2:0]               ALUctrl,
    output logic                     ALUsrc,
    output logic [1:0]               ImmSrc,
    output logic                     PCWrite,
    output logic                     PCsrc,
    output logic                     illegal,
    output logic                     retire,
    output logic [CNT_WIDTH-1:0]     instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_BNE  = 7'b1100011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t               state;
    logic [6:0]           opcode_q;
    logic [2:0]           fn3_q;
    logic                 illegal_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 is_addi, is_bne, is_lw, is_sw;
    logic                 decode_legal;
    logic                 unused_instr_bits;

    assign unused_instr_bits = ^{instr[ADDRESS_WIDTH-1:15], instr[11:7]};

    // Operation held for EXEC/MEM/WB comes only from the copy latched in DECODE.
    assign is_addi = (opcode_q == OP_ADDI) && (fn3_q == 3'b000);
    assign is_bne  = (opcode_q == OP_BNE)  && (fn3_q == 3'b001);
    assign is_lw   = (opcode_q == OP_LW)   && (fn3_q == 3'b010);
    assign is_sw   = (opcode_q == OP_SW)   && (fn3_q == 3'b010);

    assign decode_legal = ((instr[6:0] == OP_ADDI) && (instr[14:12] == 3'b000)) ||
                          ((instr[6:0] == OP_BNE)  && (instr[14:12] == 3'b001)) ||
                          ((instr[6:0] == OP_LW)   && (instr[14:12] == 3'b010)) ||
                          ((instr[6:0] == OP_SW)   && (instr[14:12] == 3'b010));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FETCH;
            opcode_q  <= '0;
            fn3_q     <= '0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            if (retire)
                count_q <= count_q + CNT_ONE;
            case (state)
                FETCH:
                    if (mem_ready)
                        state <= DECODE;
                DECODE: begin
                    opcode_q <= instr[6:0];
                    fn3_q    <= instr[14:12];
                    if (decode_legal) begin
                        state <= EXEC;
                    end else begin
                        state     <= TRAP;
                        illegal_q <= 1'b1;
                    end
                end
                EXEC:
                    if (is_addi)
                        state <= WB;
                    else if (is_bne)
                        state <= FETCH;
                    else if (is_lw || is_sw)
                        state <= MEM;
                    else
                        state <= TRAP;
                MEM:
                    if (mem_ready)
                        state <= is_lw ? WB : FETCH;
                WB:
                    state <= FETCH;
                TRAP:
                    state <= TRAP;
                default:
                    state <= FETCH;
            endcase
        end
    end

    // Strobes are decoded from state and the latched op; a low rst_n silences all of them at once.
    always_comb begin
        InstrRead = 1'b0;
        IRWrite   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ALUctrl   = 3'b000;
        ALUsrc    = 1'b0;
        ImmSrc    = 2'b00;
        PCWrite   = 1'b0;
        PCsrc     = 1'b0;
        retire    = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    InstrRead = 1'b1;
                    IRWrite   = mem_ready;
                end
                EXEC: begin
                    if (is_bne) begin
                        ALUctrl = 3'b001;
                        ImmSrc  = 2'b10;
                        PCWrite = 1'b1;
                        PCsrc   = EQ;
                        retire  = 1'b1;
                    end else if (is_addi || is_lw || is_sw) begin
                        ALUsrc = 1'b1;
                        ImmSrc = is_sw ? 2'b01 : 2'b00;
                    end
                end
                MEM: begin
                    ALUsrc   = 1'b1;
                    ImmSrc   = is_sw ? 2'b01 : 2'b00;
                    MemRead  = is_lw;
                    MemWrite = is_sw;
                    if (is_sw && mem_ready) begin
                        PCWrite = 1'b1;
                        retire  = 1'b1;
                    end
                end
                WB: begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    retire   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign illegal = rst_n & illegal_q;
    assign instret = rst_n ? count_q : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: the stimulus side pushes one expected
// output snapshot per cycle from an instruction-level model, a monitor pops and compares.
module tb_multicycle_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   instr = '0;
    logic          EQ = 1'b0;
    logic          mem_ready = 1'b0;
    logic          InstrRead, IRWrite, MemRead, MemWrite, RegWrite;
    logic [2:0]    ALUctrl;
    logic          ALUsrc;
    logic [1:0]    ImmSrc;
    logic          PCWrite, PCsrc, illegal, retire;
    logic [CW-1:0] instret;

    multicycle_control #(.ADDRESS_WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .EQ(EQ), .mem_ready(mem_ready),
        .InstrRead(InstrRead), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc),
        .PCWrite(PCWrite), .PCsrc(PCsrc), .illegal(illegal), .retire(retire),
        .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          instr_read;
        logic          ir_write;
        logic          mem_read;
        logic          mem_write;
        logic          reg_write;
        logic [2:0]    alu_ctrl;
        logic          alu_src;
        logic [1:0]    imm_src;
        logic          pc_write;
        logic          pc_src;
        logic          illegal;
        logic          retire;
        logic [CW-1:0] instret;
    } outs_t;

    typedef enum int { K_ADDI, K_BNE, K_LW, K_SW, K_ILL } kind_t;

    outs_t exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    stim_done = 0;

    int    retired_total = 0;
    bit    illegal_m = 0;

    function automatic outs_t base();
        outs_t e;
        e = '0;
        e.illegal = illegal_m;
        e.instret = CW'(retired_total % (1 << CW));
        return e;
    endfunction

    function automatic bit is_legal(input logic [31:0] w);
        return (w[6:0] == 7'b0010011 && w[14:12] == 3'b000) ||
               (w[6:0] == 7'b1100011 && w[14:12] == 3'b001) ||
               (w[6:0] == 7'b0000011 && w[14:12] == 3'b010) ||
               (w[6:0] == 7'b0100011 && w[14:12] == 3'b010);
    endfunction

    function automatic logic [31:0] make_word(input kind_t k);
        logic [31:0] w;
        w = $urandom;
        case (k)
            K_ADDI: begin w[6:0] = 7'b0010011; w[14:12] = 3'b000; end
            K_BNE:  begin w[6:0] = 7'b1100011; w[14:12] = 3'b001; end
            K_LW:   begin w[6:0] = 7'b0000011; w[14:12] = 3'b010; end
            K_SW:   begin w[6:0] = 7'b0100011; w[14:12] = 3'b010; end
            default: while (is_legal(w)) w = $urandom;
        endcase
        return w;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [31:0] ir, input logic eq,
                                 input logic mr, input outs_t e, input string tag);
        @(posedge clk);
        #1;
        rst_n     = rst;
        instr     = ir;
        EQ        = eq;
        mem_ready = mr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic checkOutput(input outs_t e, input string tag);
        outs_t a;
        a = {InstrRead, IRWrite, MemRead, MemWrite, RegWrite, ALUctrl, ALUsrc, ImmSrc,
             PCWrite, PCsrc, illegal, retire, instret};
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b required %b (ir,ird,mr,mw,rw,alu,src,imm,pcw,pcs,ill,ret,cnt)",
                     tag, $time, a, e);
        end
    endtask

    task automatic doReset(input int cycles);
        outs_t e;
        e = '0;
        for (int i = 0; i < cycles; i++)
            applyStimulus(1'b0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, "reset");
        retired_total = 0;
        illegal_m     = 0;
    endtask

    // One instruction at the level of "what the shared port and datapath must see each cycle".
    // eq_sel: 0/1 forces the branch condition, 2 picks it at random.
    task automatic runInstr(input kind_t k, input logic [31:0] w, input int eq_sel,
                            input int fetch_stalls, input int mem_stalls, input bit abort_mem);
        outs_t e;
        logic  eq;
        for (int i = 0; i < fetch_stalls; i++) begin
            e = base(); e.instr_read = 1;
            applyStimulus(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0, e, "fetch-wait");
        end
        e = base(); e.instr_read = 1; e.ir_write = 1;
        applyStimulus(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b1, e, "fetch-done");
        e = base();
        applyStimulus(1'b1, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, "decode");

        if (k == K_ILL) begin
            illegal_m = 1;
            for (int i = 0; i < 10; i++) begin
                e = base();
                applyStimulus(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, "trap");
            end
            doReset(2);
            return;
        end

        if (k == K_BNE) begin
            eq = (eq_sel == 2) ? 1'($urandom_range(0, 1)) : 1'(eq_sel);
            e = base(); e.alu_ctrl = 3'b001; e.imm_src = 2'b10; e.pc_write = 1; e.pc_src = eq; e.retire = 1;
            applyStimulus(1'b1, $urandom, eq, 1'($urandom_range(0, 1)), e, "exec-bne");
            retired_total++;
            return;
        end

        e = base(); e.alu_src = 1; e.imm_src = (k == K_SW) ? 2'b01 : 2'b00;
        applyStimulus(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e,
                      (k == K_ADDI) ? "exec-addi" : "exec-mem");

        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i < mem_stalls; i++) begin
                e = base(); e.alu_src = 1; e.imm_src = (k == K_SW) ? 2'b01 : 2'b00;
                e.mem_read = (k == K_LW); e.mem_write = (k == K_SW);
                applyStimulus(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0, e, "mem-wait");
            end
            if (abort_mem) begin
                doReset(1);
                return;
            end
            e = base(); e.alu_src = 1; e.imm_src = (k == K_SW) ? 2'b01 : 2'b00;
            e.mem_read = (k == K_LW); e.mem_write = (k == K_SW);
            if (k == K_SW) begin
                e.pc_write = 1; e.retire = 1;
            end
            applyStimulus(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b1, e, "mem-done");
            if (k == K_SW) begin
                retired_total++;
                return;
            end
        end

        e = base(); e.reg_write = 1; e.pc_write = 1; e.retire = 1;
        applyStimulus(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, "writeback");
        retired_total++;
    endtask

    initial begin
        kind_t k;
        int    r;
        doReset(2);
        runInstr(K_ADDI, 32'h00500093, 2, 3, 0, 0);
        runInstr(K_BNE,  32'hFE209EE3, 1, 0, 0, 0);
        runInstr(K_BNE,  32'hFE209EE3, 0, 0, 0, 0);
        runInstr(K_LW,   32'h0000A103, 2, 0, 2, 0);
        runInstr(K_SW,   32'h0020A023, 2, 0, 0, 0);
        runInstr(K_ILL,  32'h00000033, 2, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            runInstr(K_ADDI, make_word(K_ADDI), 2, 0, 0, 0);
        runInstr(K_LW, 32'h0000A103, 2, 0, 1, 1);
        runInstr(K_ADDI, 32'h00500093, 2, 0, 0, 0);
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 25)      k = K_ADDI;
            else if (r < 50) k = K_BNE;
            else if (r < 72) k = K_LW;
            else if (r < 94) k = K_SW;
            else             k = K_ILL;
            runInstr(k, make_word(k), 2, $urandom_range(0, 2), $urandom_range(0, 2),
                     (k == K_LW || k == K_SW) && ($urandom_range(0, 19) == 0));
        end
        stim_done = 1;
    end

    initial begin
        outs_t e;
        string t;
        int    idle;
        idle = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checkOutput(e, t);
            end else if (stim_done) begin
                break;
            end
            if (stim_done) begin
                idle++;
                if (idle > 10) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL drain: got %0d pending expectations required 0", exp_q.size());
                    break;
                end
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle control FSM for the reduced RISC-V core. It replaces single-cycle flag decoding with a sequenced FETCH/DECODE/EXEC/MEM/WB flow, which lets instruction and data share one memory port with a ready handshake. It drives the same datapath strobes as the existing decoder, adds memory, IR and PC write enables, traps illegal opcodes and counts retired instructions.

Parameters:
ADDRESS_WIDTH, 32, instruction word width.
CNT_WIDTH, 32, width of retired-instruction counter.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  synchronous, active-low reset.
instr  in  ADDRESS_WIDTH  current IR contents from datapath.
EQ  in  1  1 when rs1 != rs2 (branch-taken condition for bne).
mem_ready  in  1  shared memory completes current access this cycle.
InstrRead  out  1  memory read request for instruction fetch.
IRWrite  out  1  load IR from memory read data.
MemRead  out  1  data memory read request (lw).
MemWrite  out  1  data memory write request (sw).
RegWrite  out  1  register file write enable.
ALUctrl  out  3  000 add, 001 sub; all other codes unused.
ALUsrc  out  1  1 = immediate operand B, 0 = rs2.
ImmSrc  out  2  00 I-type, 01 S-type, 10 B-type.
PCWrite  out  1  PC update enable.
PCsrc  out  1  0 = PC+4, 1 = branch target.
illegal  out  1  sticky illegal-instruction flag.
retire  out  1  one-cycle pulse when an instruction completes.
instret  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are Moore: decoded from state plus the opcode/fn3 latched in DECODE. Exceptions: IRWrite and the final strobes are qualified by mem_ready where stated.
- Reset (rst_n=0 at clock edge): state=FETCH, illegal=0, instret=0, latched opcode=0. While rst_n=0, all outputs are forced to 0. Reset takes priority over every transition, including a pending memory access, which is aborted.
- FETCH: InstrRead=1. While mem_ready=0, hold. When mem_ready=1: IRWrite=1 in the same cycle, then go to DECODE.
- DECODE: no strobes. Latch instr[6:0] and instr[14:12].
  - Legal instructions: addi (0010011, fn3 000), bne (1100011, fn3 001), lw (0000011, fn3 010), sw (0100011, fn3 010). Legal -> EXEC.
  - Anything else -> TRAP.
- EXEC:
  - addi: ALUctrl=000, ALUsrc=1, ImmSrc=00; -> WB.
  - bne: ALUctrl=001, ALUsrc=0, ImmSrc=10, PCWrite=1, PCsrc=EQ, retire=1; -> FETCH.
  - lw: ALUctrl=000, ALUsrc=1, ImmSrc=00; -> MEM.
  - sw: ALUctrl=000, ALUsrc=1, ImmSrc=01; -> MEM.
- MEM: address strobes held from EXEC (ALUctrl=000, ALUsrc=1, ImmSrc per op).
  - lw: MemRead=1 until mem_ready; then -> WB.
  - sw: MemWrite=1 until mem_ready. In the mem_ready cycle: PCWrite=1, PCsrc=0, retire=1; then -> FETCH.
- WB: RegWrite=1, PCWrite=1, PCsrc=0, retire=1; -> FETCH.
- TRAP: all strobes 0, illegal=1. Remains in TRAP until reset; instret frozen.
- Request exclusivity: at most one of InstrRead/MemRead/MemWrite is high in any cycle. mem_ready is ignored when no request is asserted.
- Strobe persistence: RegWrite, PCWrite and retire each last exactly one cycle per instruction.
- instret increments by 1 on each retire cycle and wraps modulo 2^CNT_WIDTH (all-ones -> 0) with no flag.
- Latency with mem_ready tied high: addi 4 cycles, bne 3, lw 5, sw 4, measured from FETCH entry to the next FETCH entry. Each mem_ready=0 cycle adds one cycle.
- instr changes outside DECODE do not affect the decoded operation.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then release, mem_ready=0 for 3 cycles -> all outputs 0 during reset; InstrRead=1 held, IRWrite=0, state stays FETCH; then mem_ready=1 -> IRWrite=1 that cycle.
- addi x1,x0,5 (0x00500093), mem_ready=1 -> EXEC shows ALUsrc=1, ALUctrl=000; WB shows RegWrite=1, PCWrite=1, PCsrc=0; retire on cycle 4; instret 0->1.
- bne (0xFE209EE3) with EQ=1, then again with EQ=0 -> EXEC PCWrite=1, PCsrc=1 then 0; ALUctrl=001, ImmSrc=10; 3-cycle latency each; RegWrite never asserted.
- lw (0x0000A103) with mem_ready low for 2 cycles in MEM -> MemRead=1 for 3 cycles, then WB RegWrite=1; total 7 cycles. sw (0x0020A023) -> MemWrite=1 and ImmSrc=01, no RegWrite.
- Opcode 0x00000033 (R-type add) -> DECODE -> TRAP; illegal=1 stays high and strobes stay 0 for 10 cycles; instret unchanged; rst_n=0 clears illegal and returns to FETCH.
- Preload instret to all-ones via repeated retires (or CNT_WIDTH=4 run of 16 addi) -> wraps to 0. Assert rst_n=0 mid-MEM of lw -> MemRead drops that cycle, no RegWrite, FETCH after release.
